// File: rtl/util_ext_sync_capture.sv
// External-sync capture gate: detects the sync-arrived event (sync_armed falling without a
// disarm) and opens a delayed, length-limited window on a valid-qualified sample stream.
module util_ext_sync_capture #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int ENABLED     = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   sync_armed,
  input  logic                   ext_sync_disarm,
  input  logic [COUNT_WIDTH-1:0] cfg_delay,
  input  logic [COUNT_WIDTH-1:0] cfg_length,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_out_valid,
  output logic                   capture_active,
  output logic                   capture_done,
  output logic                   capture_aborted
);

  generate
    if (ENABLED != 0) begin : g_cap
      localparam logic [1:0] S_IDLE    = 2'd0;
      localparam logic [1:0] S_WAIT    = 2'd1;
      localparam logic [1:0] S_DELAY   = 2'd2;
      localparam logic [1:0] S_CAPTURE = 2'd3;
      localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

      logic [1:0]             state, state_nxt;
      logic                   armed_d, dis_d, dis_seen;
      logic [COUNT_WIDTH-1:0] dly_cnt, beat_cnt, lat_delay, lat_len;
      logic                   rise, fall, dis_edge, disarm_fall, sync_evt, last_beat;

      assign rise     = sync_armed & ~armed_d;
      assign fall     = ~sync_armed & armed_d;
      assign dis_edge = ext_sync_disarm & ~dis_d;
      // The arming stage drops sync_armed one cycle after the disarm edge, so both
      // the current and the previous disarm edge classify a fall as a disarm.
      assign disarm_fall = fall & (dis_edge | dis_seen);
      assign sync_evt    = fall & ~(dis_edge | dis_seen);
      assign last_beat   = data_in_valid && (lat_len != '0) && ((beat_cnt + CNT_ONE) == lat_len);

      always_comb begin
        state_nxt = state;
        case (state)
          S_IDLE:    if (rise) state_nxt = S_WAIT;
          S_WAIT: begin
            if (disarm_fall)   state_nxt = S_IDLE;
            else if (sync_evt) state_nxt = (lat_delay == '0) ? S_CAPTURE : S_DELAY;
          end
          S_DELAY: begin
            if (dis_edge)                state_nxt = S_IDLE;
            else if (dly_cnt == CNT_ONE) state_nxt = S_CAPTURE;
          end
          default: if (last_beat || dis_edge) state_nxt = S_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          state           <= S_IDLE;
          armed_d         <= 1'b0;
          dis_d           <= 1'b0;
          dis_seen        <= 1'b0;
          dly_cnt         <= '0;
          beat_cnt        <= '0;
          lat_delay       <= '0;
          lat_len         <= '0;
          data_out        <= '0;
          data_out_valid  <= 1'b0;
          capture_active  <= 1'b0;
          capture_done    <= 1'b0;
          capture_aborted <= 1'b0;
        end else begin
          armed_d  <= sync_armed;
          dis_d    <= ext_sync_disarm;
          dis_seen <= dis_edge;
          state    <= state_nxt;

          if (state == S_IDLE && rise) begin
            lat_delay <= cfg_delay;
            lat_len   <= cfg_length;
          end

          if (state == S_WAIT && sync_evt) dly_cnt <= lat_delay;
          else if (state == S_DELAY)       dly_cnt <= dly_cnt - CNT_ONE;

          if (state != S_CAPTURE)  beat_cnt <= '0;
          else if (data_in_valid)  beat_cnt <= beat_cnt + CNT_ONE;

          if (state == S_CAPTURE) data_out <= data_in;
          data_out_valid <= (state == S_CAPTURE) && data_in_valid;

          // Active stays high through the cycle that presents the final beat.
          capture_active  <= (state_nxt == S_DELAY) || (state_nxt == S_CAPTURE) ||
                             (state == S_CAPTURE);
          capture_done    <= (state == S_CAPTURE) && last_beat;
          capture_aborted <= (state != S_IDLE) && (state_nxt == S_IDLE) &&
                             !((state == S_CAPTURE) && last_beat);
        end
      end
    end else begin : g_pass
      logic unused_inputs;
      assign unused_inputs = ^{sync_armed, ext_sync_disarm, cfg_delay, cfg_length};

      always_ff @(posedge clk) begin
        if (!resetn) begin
          data_out       <= '0;
          data_out_valid <= 1'b0;
        end else begin
          data_out       <= data_in;
          data_out_valid <= data_in_valid;
        end
      end

      assign capture_active  = 1'b0;
      assign capture_done    = 1'b0;
      assign capture_aborted = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_util_ext_sync_capture.sv
// Bench for util_ext_sync_capture: directed window scenarios plus random traffic, all
// checked every cycle against a window-level model; an ENABLED=0 instance is checked too.
module tb_util_ext_sync_capture;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sync_armed = 1'b0;
  logic          ext_sync_disarm = 1'b0;
  logic [CW-1:0] cfg_delay = '0;
  logic [CW-1:0] cfg_length = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;

  logic [DW-1:0] data_out, data_out_p;
  logic          data_out_valid, capture_active, capture_done, capture_aborted;
  logic          data_out_valid_p, capture_active_p, capture_done_p, capture_aborted_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  util_ext_sync_capture #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ENABLED(1)) dut (
    .clk(clk), .resetn(resetn), .sync_armed(sync_armed), .ext_sync_disarm(ext_sync_disarm),
    .cfg_delay(cfg_delay), .cfg_length(cfg_length), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_out(data_out), .data_out_valid(data_out_valid),
    .capture_active(capture_active), .capture_done(capture_done),
    .capture_aborted(capture_aborted));

  util_ext_sync_capture #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ENABLED(0)) dut_pass (
    .clk(clk), .resetn(resetn), .sync_armed(sync_armed), .ext_sync_disarm(ext_sync_disarm),
    .cfg_delay(cfg_delay), .cfg_length(cfg_length), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_out(data_out_p), .data_out_valid(data_out_valid_p),
    .capture_active(capture_active_p), .capture_done(capture_done_p),
    .capture_aborted(capture_aborted_p));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Window-level model: phase 0 idle, 1 armed/waiting, 2 delaying until cycle open_at, 3 capturing.
  int cyc = 0;
  int m_phase = 0, m_open_at = 0, m_lat_d = 0, m_lat_l = 0, m_beats = 0;
  bit m_prev_armed = 0, m_prev_dis = 0, m_dis_recent = 0;
  logic [DW-1:0] e_dout = '0, e_pdout = '0;
  bit e_dv = 0, e_act = 0, e_done = 0, e_abt = 0, e_pdv = 0;

  always @(posedge clk) begin
    bit rise, fall, dedge, disarm_ev, sync_ev, was_cap;
    rise      = sync_armed && !m_prev_armed;
    fall      = !sync_armed && m_prev_armed;
    dedge     = ext_sync_disarm && !m_prev_dis;
    disarm_ev = fall && (dedge || m_dis_recent);
    sync_ev   = fall && !disarm_ev;
    if (!resetn) begin
      m_phase = 0; m_beats = 0; m_lat_d = 0; m_lat_l = 0;
      m_prev_armed = 0; m_prev_dis = 0; m_dis_recent = 0;
      e_dout = '0; e_dv = 0; e_act = 0; e_done = 0; e_abt = 0;
      e_pdout = '0; e_pdv = 0;
    end else begin
      e_pdout = data_in; e_pdv = data_in_valid;
      e_dv = 0; e_done = 0; e_abt = 0;
      was_cap = (m_phase == 3);
      case (m_phase)
        0: if (rise) begin m_phase = 1; m_lat_d = int'(cfg_delay); m_lat_l = int'(cfg_length); end
        1: begin
          if (disarm_ev) begin m_phase = 0; e_abt = 1; end
          else if (sync_ev) begin
            m_beats = 0;
            if (m_lat_d == 0) m_phase = 3;
            else begin m_phase = 2; m_open_at = cyc + 1 + m_lat_d; end
          end
        end
        2: begin
          if (dedge) begin m_phase = 0; e_abt = 1; end
          else if (cyc + 1 == m_open_at) begin m_phase = 3; m_beats = 0; end
        end
        default: begin
          e_dout = data_in;
          e_dv = data_in_valid;
          if (data_in_valid) m_beats++;
          if (m_lat_l != 0 && data_in_valid && m_beats == m_lat_l) begin m_phase = 0; e_done = 1; end
          else if (dedge) begin m_phase = 0; e_abt = 1; end
        end
      endcase
      e_act = (m_phase == 2) || (m_phase == 3) || was_cap;
      m_prev_armed = sync_armed; m_prev_dis = ext_sync_disarm; m_dis_recent = dedge;
    end
    cyc++;
    #1;
    check("data_out_valid", data_out_valid, e_dv);
    if (e_dv) check("data_out", data_out, e_dout);
    check("capture_active", capture_active, e_act);
    check("capture_done", capture_done, e_done);
    check("capture_aborted", capture_aborted, e_abt);
    check("pass_valid", data_out_valid_p, e_pdv);
    check("pass_data", data_out_p, e_pdout);
    check("pass_status", {capture_active_p, capture_done_p, capture_aborted_p}, 3'b000);
  end

  task automatic arm_and_wait();
    @(negedge clk); sync_armed = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nv, nd, na;
    // Reset held with valid input
    data_in_valid = 1'b1; data_in = 32'hdead_beef;
    repeat (5) @(negedge clk);
    check("reset_valid", data_out_valid, 1'b0);
    check("reset_data", data_out, '0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_valid", data_out_valid, 1'b0);
    check("post_reset_active", capture_active, 1'b0);

    // Basic window: delay 3, length 4, continuous ramp
    cfg_delay = 3; cfg_length = 4; data_in_valid = 1'b1;
    arm_and_wait();
    sync_armed = 1'b0; data_in = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("basic_valid", data_out_valid, (k >= 5 && k <= 8));
      if (k >= 5 && k <= 8) check("basic_data", data_out, k - 1);
      check("basic_done", capture_done, (k == 8));
      check("basic_active", capture_active, (k >= 1 && k <= 8));
      data_in = k;
    end

    // Gapped input: delay 0, length 3, valid pattern 1,0,0,1,0,1,1
    begin
      bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      cfg_delay = 0; cfg_length = 3; data_in_valid = 1'b0;
      arm_and_wait();
      sync_armed = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        check("gap_valid", data_out_valid, (k == 2 || k == 5 || k == 7));
        if (k == 2 || k == 5 || k == 7) check("gap_data", data_out, 100 + k - 1);
        check("gap_done", capture_done, (k == 7));
        data_in_valid = (k <= 7) ? pat[k-1] : 1'b0;
        data_in = 100 + k;
      end
    end

    // Disarm while waiting: sync_armed falls one cycle after the disarm pulse
    cfg_delay = 2; cfg_length = 2; data_in_valid = 1'b1;
    arm_and_wait();
    ext_sync_disarm = 1'b1;
    @(negedge clk); ext_sync_disarm = 1'b0; sync_armed = 1'b0;
    @(negedge clk);
    check("disarm_aborted", capture_aborted, 1'b1);
    check("disarm_active", capture_active, 1'b0);
    @(negedge clk);
    check("disarm_pulse_len", capture_aborted, 1'b0);
    check("disarm_no_window", data_out_valid, 1'b0);

    // Unlimited window with a re-arm mid-capture, then disarm
    cfg_delay = 2; cfg_length = 0; data_in_valid = 1'b0;
    arm_and_wait();
    sync_armed = 1'b0;
    nv = 0; nd = 0; na = 0;
    for (int k = 1; k <= 112; k++) begin
      @(negedge clk);
      nv += int'(data_out_valid); nd += int'(capture_done); na += int'(capture_aborted);
      data_in_valid = (k >= 3 && k <= 102);
      data_in = $urandom;
      if (k == 50) sync_armed = 1'b1;
      ext_sync_disarm = (k == 105);
      if (k == 106) sync_armed = 1'b0;
    end
    check("unlim_beats", nv, 100);
    check("unlim_done", nd, 0);
    check("unlim_aborted", na, 1);

    // Reset in the middle of a capture
    cfg_delay = 0; cfg_length = 0; data_in_valid = 1'b1;
    arm_and_wait();
    sync_armed = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_pre_valid", data_out_valid, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset_valid", data_out_valid, 1'b0);
    check("midreset_pulses", {capture_done, capture_aborted}, 2'b00);
    @(negedge clk); resetn = 1'b1;

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      resetn          = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 9) == 0) sync_armed = ~sync_armed;
      ext_sync_disarm = ($urandom_range(0, 29) == 0);
      data_in_valid   = ($urandom_range(0, 9) < 6);
      data_in         = $urandom;
      cfg_delay       = CW'($urandom_range(0, 4));
      cfg_length      = CW'($urandom_range(0, 6));
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/util_ext_sync_capture.md
Name: util_ext_sync_capture

Overview:
Downstream companion of the external-sync arming stage. It consumes the `sync_armed` flag and the raw disarm request, and detects the "sync arrived" event: a falling edge of `sync_armed` that is not caused by a disarm. On that event it opens a gated capture window on a valid-qualified sample stream, after a programmable delay and for a programmable number of beats. It sits between the ADC/data-path sample stream and the DMA/packing stage.

Parameters:
- DATA_WIDTH, 32: width of the sample bus.
- COUNT_WIDTH, 16: width of the delay and length counters and config inputs.
- ENABLED, 1: when 0, the block is a transparent 1-cycle register stage.
  - `data_out`/`data_out_valid` follow `data_in`/`data_in_valid`.
  - All status outputs are held at 0.

Ports:
- clk  input  1  block clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- sync_armed  input  1  armed flag from the external-sync arming stage, same clock.
- ext_sync_disarm  input  1  raw disarm request, the same signal that feeds the arming stage.
- cfg_delay  input  COUNT_WIDTH  idle cycles between sync event and window open.
- cfg_length  input  COUNT_WIDTH  valid beats to pass; 0 = unlimited until disarm.
- data_in  input  DATA_WIDTH  sample data.
- data_in_valid  input  1  sample qualifier.
- data_out  output  DATA_WIDTH  gated sample data.
- data_out_valid  output  1  gated qualifier.
- capture_active  output  1  high in DELAY and CAPTURE.
- capture_done  output  1  1-cycle pulse when cfg_length beats have been passed.
- capture_aborted  output  1  1-cycle pulse when a window or pending wait is cancelled by disarm.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, counters=0, internal edge registers=0, all outputs=0.
  - Reset mid-operation abandons the window immediately, with no done/aborted pulse.
- Edge detection:
  - `armed_d` is a registered copy of `sync_armed`.
  - `rise` = sync_armed & ~armed_d.
  - `fall` = ~sync_armed & armed_d.
  - `dis_edge` = ext_sync_disarm & ~dis_d.
  - `dis_seen` = `dis_edge` registered one cycle.
- Disarm vs. sync event:
  - `fall` with (`dis_edge` | `dis_seen`) is a disarm.
  - Any other `fall` is a sync event.
  - This covers the arming stage's 1-cycle registered output delay.
- State IDLE:
  - `rise` → WAIT_SYNC.
  - On entry to WAIT_SYNC, latch cfg_delay and cfg_length; later config changes are ignored until the next IDLE.
- State WAIT_SYNC:
  - Sync event in cycle T with latched delay D=0 → CAPTURE in T+1.
  - Sync event with D>0 → DELAY, counter loaded with D.
  - Disarm → IDLE and pulse capture_aborted in T+1.
- State DELAY:
  - Counter decrements each cycle; on reaching 0, enter CAPTURE. CAPTURE is therefore entered at T+1+D.
  - A `dis_edge` → IDLE and pulse capture_aborted.
- State CAPTURE:
  - Each cycle, data_out <= data_in and data_out_valid <= data_in_valid (1-cycle latency).
  - The beat counter increments on every data_in_valid.
  - When the accepted beat is number L (latched length, L≠0), the state returns to IDLE in the next cycle and capture_done pulses in that same cycle, coincident with the last data_out_valid.
  - L=0: run until `dis_edge`, then IDLE with a capture_aborted pulse. A beat present in the disarm cycle is still passed.
- Outside CAPTURE: data_out_valid=0 and data_out holds its last value.
- Gaps: data_in_valid=0 cycles do not count; exactly L valid beats are ever output per window.
- Counter width:
  - The beat counter is COUNT_WIDTH wide and never wraps for L≠0.
  - For L=0 it wraps silently.
- Ignored events:
  - `rise` while in DELAY or CAPTURE is ignored; re-arm only takes effect from IDLE.
  - A `fall` in IDLE is ignored.
- Simultaneous events: `dis_edge` in the same cycle as the L-th beat → capture_done wins (beat passed, done pulse, no aborted pulse).
- capture_done and capture_aborted are never high together.

Test Plan:
- Reset: hold resetn=0 for 5 cycles with data_in_valid=1 → all outputs 0 throughout and for 1 cycle after release.
- Basic window: cfg_delay=3, cfg_length=4, arm, continuous valid ramp 0,1,2…, sync fall at T → first data_out_valid at T+5; exactly 4 beats; capture_done coincident with the 4th beat; capture_active high T+1..T+4+4.
- Gapped input: cfg_delay=0, cfg_length=3, valid pattern 1,0,0,1,0,1,1 → outputs carry only the first 3 valid samples; capture_done on the 3rd; the 4th is not passed.
- Disarm: disarm pulse while in WAIT_SYNC (sync_armed falls one cycle later) → no window opens, capture_aborted=1 for one cycle, state IDLE.
- Unlimited: cfg_length=0, 100 valid beats, then disarm → all 100 passed, capture_aborted pulse, no capture_done.
- Mid-window events:
  - Re-arm (rise) during CAPTURE has no effect.
  - resetn=0 during CAPTURE → data_out_valid drops the next cycle, no pulses.
  - ENABLED=0 build → 1-cycle passthrough, status outputs stay 0.
